// File: rtl/xbar_arbiter.sv
// xbar_arbiter: per-slave round-robin arbiter/grant sequencer for a 2x2 cross-bar; ports: clk, resetn (sync, active-high), m_req/m_addr/s_ack in, s_valid/s_owner/m_gnt/m_ack/m_err out
module xbar_arbiter #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            m_req,
  input  logic [2*ADDR_W-1:0]   m_addr,
  input  logic [1:0]            s_ack,
  output logic [1:0]            s_valid,
  output logic [1:0]            s_owner,
  output logic [1:0]            m_gnt,
  output logic [1:0]            m_ack,
  output logic [1:0]            m_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  logic [1:0] tgt, tmo, err_nx;
  logic unused_addr;
  assign tgt = {m_addr[2*ADDR_W-1], m_addr[ADDR_W-1]};
  assign unused_addr = ^{m_addr[2*ADDR_W-2:ADDR_W], m_addr[ADDR_W-2:0]};
  for (genvar j = 0; j < 2; j++) begin : g_s
    localparam logic J = 1'(j);
    state_t st, st_nx;
    logic own, own_nx, pr, pr_nx, rel, abort, arb, tmo_j;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0] cand;
    // a granted master is never a candidate, so during BUSY only the other master can appear here
    assign cand = m_req & ~m_gnt & (J ? tgt : ~tgt);
    always_comb begin
      abort = !m_req[own] || tgt[own] != J;
      rel = st == BUSY && (s_ack[j] || abort || cnt == CW'(TIMEOUT));
      tmo_j = rel && !s_ack[j] && !abort;
      arb = st == IDLE || rel;
      pr_nx = rel ? !own : pr;
      st_nx = arb ? (|cand ? BUSY : IDLE) : st;
      own_nx = (arb && |cand) ? (cand[pr_nx] ? pr_nx : !pr_nx) : own;
      cnt_nx = arb ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (resetn) begin
        st <= IDLE;
        own <= 1'b0;
        pr <= 1'b0;
        cnt <= '0;
      end else begin
        st <= st_nx;
        own <= own_nx;
        pr <= pr_nx;
        cnt <= cnt_nx;
      end
    end
    assign s_valid[j] = st == BUSY;
    assign s_owner[j] = own;
    assign tmo[j] = tmo_j;
  end
  always_comb begin
    m_gnt = '0;
    m_ack = '0;
    for (int j = 0; j < 2; j++) begin
      if (s_valid[j]) begin
        m_gnt[s_owner[j]] = 1'b1;
        m_ack[s_owner[j]] = m_ack[s_owner[j]] | s_ack[j];
      end
    end
  end
  always_comb begin
    err_nx = '0;
    for (int j = 0; j < 2; j++)
      if (tmo[j]) err_nx[s_owner[j]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (resetn) m_err <= '0;
    else m_err <= err_nx;
  end
endmodule

// File: tb/tb_xbar_arbiter.sv
// tb_xbar_arbiter: directed bench with a behavioural per-cycle model and literal checkpoints
module tb_xbar_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] m_req, s_ack, s_valid, s_owner, m_gnt, m_ack, m_err;
  logic [63:0] m_addr;
  int cmp = 0;
  int bad = 0;

  xbar_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(rst), .m_req(m_req), .m_addr(m_addr), .s_ack(s_ack),
    .s_valid(s_valid), .s_owner(s_owner), .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // model: which slave each master holds, owner, busy-cycle count, preferred master
  bit mb[2];
  int mo[2], mc[2], mp[2];
  bit [1:0] me, held;
  bit go = 0;
  int o, c;

  function automatic int tg(input int i);
    return int'(m_addr[i*32+31]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mb = '{0, 0}; mo = '{0, 0}; mc = '{0, 0}; mp = '{0, 0}; me = 0; go = 1;
    end else begin
      held = 0;
      for (int j = 0; j < 2; j++) if (mb[j]) held[mo[j]] = 1;
      me = 0;
      for (int j = 0; j < 2; j++) begin
        if (mb[j]) begin
          o = mo[j];
          if (s_ack[j] || !m_req[o] || tg(o) != j) mb[j] = 0;
          else if (mc[j] == TO) begin mb[j] = 0; me[o] = 1; end
          else mc[j]++;
          if (!mb[j]) mp[j] = 1 - o;
        end
        if (!mb[j])
          for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? mp[j] : 1 - mp[j];
            if (!mb[j] && m_req[c] && tg(c) == j && !held[c]) begin
              mb[j] = 1; mo[j] = c; mc[j] = 0;
            end
          end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] ev, eg, ea;
    if (go) begin
      ev = 0; eg = 0; ea = 0;
      for (int j = 0; j < 2; j++)
        if (mb[j]) begin
          ev[j] = 1; eg[mo[j]] = 1;
          if (s_ack[j]) ea[mo[j]] = 1;
        end
      chk("model s_valid", 8'(s_valid), 8'(ev));
      chk("model m_gnt", 8'(m_gnt), 8'(eg));
      chk("model m_ack", 8'(m_ack), 8'(ea));
      chk("model m_err", 8'(m_err), 8'(me));
      for (int j = 0; j < 2; j++)
        if (mb[j]) chk("model s_owner", 8'(s_owner[j]), 8'(mo[j]));
    end
  end

  initial begin
    rst = 1; m_req = 0; s_ack = 0; m_addr = 0;
    step(2);
    #1 chk("reset s_valid", 8'(s_valid), 8'h0);
    chk("reset s_owner", 8'(s_owner), 8'h0);
    chk("reset m_gnt", 8'(m_gnt), 8'h0);
    chk("reset m_err", 8'(m_err), 8'h0);
    // single request
    rst = 0; m_req = 2'b01; m_addr[31:0] = 32'h0000_0010;
    step(1);
    #1 chk("single s_valid", 8'(s_valid), 8'h1);
    chk("single s_owner0", 8'(s_owner[0]), 8'h0);
    step(2);
    s_ack = 2'b01;
    #1 chk("single m_ack", 8'(m_ack), 8'h1);
    step(1);
    s_ack = 0; m_req = 0;
    #1 chk("single drop", 8'(s_valid), 8'h0);
    // contention on slave_2
    m_addr = {32'h8000_0000, 32'h8000_0000}; m_req = 2'b11;
    step(1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr owner", 8'(s_owner[1]), 8'(k % 2));
      chk("rr valid", 8'(s_valid), 8'h2);
      step(1);
      s_ack = 2'b10;
      #1 chk("rr m_ack", 8'(m_ack), (k % 2) ? 8'h2 : 8'h1);
      step(1);
      s_ack = 0;
    end
    m_req = 0;
    step(1);
    #1 chk("rr end", 8'(s_valid), 8'h0);
    // parallel grants
    m_addr = {32'h8000_0000, 32'h0000_0000}; m_req = 2'b11;
    step(1);
    #1 chk("par s_valid", 8'(s_valid), 8'h3);
    chk("par s_owner", 8'(s_owner), 8'h2);
    chk("par m_gnt", 8'(m_gnt), 8'h3);
    s_ack = 2'b11;
    #1 chk("par m_ack", 8'(m_ack), 8'h3);
    step(1);
    s_ack = 0; m_req = 0;
    #1 chk("par drop", 8'(s_valid), 8'h0);
    // timeout: m2 on slave_1, m1 waits
    m_addr = {32'h0000_0020, 32'h0000_0010}; m_req = 2'b10;
    step(1);
    #1 chk("to owner m2", 8'(s_owner[0]), 8'h1);
    m_req = 2'b11;
    step(4);
    #1 chk("to no err yet", 8'(m_err), 8'h0);
    chk("to still m2", 8'(s_owner[0]), 8'h1);
    step(1);
    #1 chk("to m_err", 8'(m_err), 8'h2);
    chk("to handoff", 8'(s_owner[0]), 8'h0);
    chk("to valid", 8'(s_valid), 8'h1);
    m_req = 2'b01;
    step(1);
    #1 chk("to err pulse", 8'(m_err), 8'h0);
    s_ack = 2'b01;
    #1 chk("to m1 ack", 8'(m_ack), 8'h1);
    step(1);
    s_ack = 0; m_req = 0;
    // abort
    m_addr[31:0] = 32'h8000_0000; m_req = 2'b01;
    step(1);
    #1 chk("ab grant", 8'(s_valid), 8'h2);
    step(1);
    m_req = 0;
    step(1);
    #1 chk("ab release", 8'(s_valid), 8'h0);
    // stray ack
    s_ack = 2'b10;
    #1 chk("stray m_ack", 8'(m_ack), 8'h0);
    step(1);
    s_ack = 0;
    #1 chk("stray state", 8'(s_valid), 8'h0);
    // target change while granted
    m_addr[31:0] = 32'h0000_0010; m_req = 2'b01;
    step(1);
    #1 chk("tc grant", 8'(s_valid), 8'h1);
    m_addr[31:0] = 32'h8000_0000;
    step(1);
    #1 chk("tc release", 8'(s_valid), 8'h0);
    step(1);
    #1 chk("tc regrant", 8'(s_valid), 8'h2);
    m_req = 0;
    step(1);
    // reset mid-transaction with slave_2 preferring m2
    m_addr = {32'h8000_0000, 32'h8000_0000}; m_req = 2'b11;
    step(1);
    #1 chk("rs pre owner", 8'(s_owner[1]), 8'h1);
    rst = 1;
    step(1);
    #1 chk("rs s_valid", 8'(s_valid), 8'h0);
    chk("rs s_owner", 8'(s_owner), 8'h0);
    chk("rs m_gnt", 8'(m_gnt), 8'h0);
    chk("rs m_err", 8'(m_err), 8'h0);
    rst = 0;
    step(1);
    #1 chk("rs prio m1", 8'(s_owner[1]), 8'h0);
    chk("rs valid", 8'(s_valid), 8'h2);
    m_req = 0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
